dmem_access_unit: RTL
=====================

Name: dmem_access_unit

Overview:
- Sits directly downstream of the single-cycle core's data-memory outputs (ALU address, register write data, MemRead/MemWrite, Byte/Half/SignExtend) and upstream of a handshaked data RAM.
- Converts each core load/store into one multi-cycle request/acknowledge transaction with byte-lane enables.
- Formats load data (lane select plus sign/zero extension) for the core.
- Raises Stall until the access completes and flags misaligned addresses.

Parameters:
- ADDR_W, 30, word-address width driven to memory (byte address bits [ADDR_W+1:2]).
- TIMEOUT_CYCLES, 255, cycles spent in WAIT before watchdog expiry (only used with DMEM_TIMEOUT_EN).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- Address  in  32  byte address from core ALU.
- DataIn  in  32  store data from core register file.
- MemRead  in  1  load request.
- MemWrite  in  1  store request.
- Byte  in  1  byte-size access.
- Half  in  1  halfword-size access.
- SignExtend  in  1  sign-extend sub-word loads (else zero-extend).
- DataOut  out  32  formatted load data to core.
- Stall  out  1  core must hold PC and state.
- EXC_AdEL  out  1  misaligned load.
- EXC_AdES  out  1  misaligned store.
- BusError  out  1  watchdog expiry pulse (tied 0 without DMEM_TIMEOUT_EN).
- MAddr  out  ADDR_W  word address to RAM.
- MWriteData  out  32  lane-replicated store data.
- MByteEn  out  4  byte-lane enables.
- ReadEnable  out  1  RAM read request.
- WriteEnable  out  1  RAM write request.
- MReadData  in  32  RAM read data, valid with DataMem_Ack.
- DataMem_Ack  in  1  RAM completion.

Behaviour:
- Reset values: state IDLE; DataOut=0; MAddr=0; MWriteData=0; MByteEn=0; ReadEnable=0; WriteEnable=0; BusError=0. Stall, EXC_AdEL and EXC_AdES are combinational and evaluate to 0 in IDLE with no request.
- Request decoding:
  - MemWrite has priority; MemRead with MemWrite is treated as a store.
  - Byte has priority over Half. Neither set means word.
- Alignment: misaligned if Half and Address[0]=1, or word and Address[1:0]!=0.
  - Misaligned: EXC_AdEL (load) or EXC_AdES (store) asserts combinationally, Stall=0, no memory request, state stays IDLE.
- Lanes are little-endian, lane = Address[1:0].
  - MByteEn: byte = 4'b0001<<lane; half = Address[1] ? 4'b1100 : 4'b0011; word = 4'b1111.
  - MWriteData: byte = {4{DataIn[7:0]}}; half = {2{DataIn[15:0]}}; word = DataIn.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: on an aligned request, Stall=1 combinationally. At the clock edge, register MAddr=Address[ADDR_W+1:2], MByteEn, MWriteData, and ReadEnable or WriteEnable (exactly one); latch size, lane and SignExtend internally; go to WAIT.
  - WAIT: Stall=1, outputs held stable. Core inputs are ignored, so address changes have no effect. On DataMem_Ack=1 at the edge:
    - for a load, register DataOut = lane-selected, extended MReadData;
    - deassert enables;
    - go to DONE.
  - DONE: Stall=0 for exactly one cycle so the core retires the instruction. The next edge goes to IDLE.
- Timing:
  - Minimum access: 3 cycles (IDLE req, WAIT ack, DONE).
  - Each extra ack-less WAIT cycle adds one.
  - Back-to-back accesses re-enter via IDLE.
- Load extraction:
  - byte = MReadData[8*lane+7 -: 8], extended by bit 7;
  - half = Address[1] ? [31:16] : [15:0], extended by bit 15;
  - word unmodified.
- Stores leave DataOut unchanged.
- DataOut holds its value until the next completed load.
- DataMem_Ack is ignored in IDLE and DONE; spurious acks are discarded.
- Reset asserted mid-WAIT: enables drop immediately (asynchronous), state IDLE, the transaction is abandoned, and the RAM must tolerate the aborted request.

Optional Feature:
- Macro DMEM_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - Reaching TIMEOUT_CYCLES: enables drop, load DataOut=0, BusError=1 for the DONE cycle only, go to DONE.
  - Ack in the same cycle as expiry wins (normal completion, BusError=0).
- Not defined: no counter, BusError tied 0, WAIT lasts indefinitely until ack.

Test Plan:
- Word load, Address=0x100, MReadData=0xDEADBEEF, ack on first WAIT cycle -> MAddr=0x40, MByteEn=4'b1111, ReadEnable high 1 cycle, Stall high 2 cycles then low 1, DataOut=0xDEADBEEF.
- Byte store, Address=0x203, DataIn=0x000000A5 -> MByteEn=4'b1000, MWriteData=0xA5A5A5A5, WriteEnable high, DataOut unchanged.
- Signed half load, Address=0x12, MReadData=0x8001_7FFF, SignExtend=1 -> DataOut=0xFFFF8001; same with SignExtend=0 -> 0x00008001.
- Misaligned word load at 0x102 and half store at 0x7 -> EXC_AdEL=1 / EXC_AdES=1 respectively, Stall=0, no enable ever asserted.
- Ack delayed 5 cycles; Address toggled during WAIT; RST pulsed in a second run mid-WAIT -> Stall high 6 cycles, MAddr stable; reset drops ReadEnable the same cycle and DataOut=0.
- With DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> after 4 WAIT cycles BusError=1 for one cycle, DataOut=0, Stall releases; without the macro -> Stall remains high.

Source files
------------

// File: rtl/dmem_access_unit.sv
// Data-memory access unit: turns single-cycle core loads/stores into handshaked RAM transactions.
// Optional watchdog on the RAM acknowledge is enabled with `define DMEM_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no access in flight; decode core request, flag misalignment
// WAIT  | request driven to RAM, waiting for DataMem_Ack (or watchdog expiry)
// DONE  | access complete; Stall low for one cycle so the core retires
module dmem_access_unit #(
  parameter int ADDR_W         = 30,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       Address,
  input  logic [31:0]       DataIn,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              Byte,
  input  logic              Half,
  input  logic              SignExtend,
  output logic [31:0]       DataOut,
  output logic              Stall,
  output logic              EXC_AdEL,
  output logic              EXC_AdES,
  output logic              BusError,
  output logic [ADDR_W-1:0] MAddr,
  output logic [31:0]       MWriteData,
  output logic [3:0]        MByteEn,
  output logic              ReadEnable,
  output logic              WriteEnable,
  input  logic [31:0]       MReadData,
  input  logic              DataMem_Ack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [31:0]       dout_q, dout_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [31:0]       mwdata_q, mwdata_d;
  logic [3:0]        be_q, be_d;
  logic              ren_q, ren_d;
  logic              wen_q, wen_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        lane_q, lane_d;
  logic              sext_q, sext_d;
  logic              load_q, load_d;

  logic              req;
  logic              misalign;
  logic [1:0]        size_in;
  logic [3:0]        be_in;
  logic [31:0]       wdata_in;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_fmt;

`ifdef DMEM_TIMEOUT_EN
  localparam int             CNT_W   = 16;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             buserr_q, buserr_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // Request decode; Byte overrides Half, a store overrides a load.
  always_comb begin
    req = MemRead | MemWrite;
    if (Byte)      size_in = SZ_BYTE;
    else if (Half) size_in = SZ_HALF;
    else           size_in = SZ_WORD;
    case (size_in)
      SZ_BYTE: begin
        misalign = 1'b0;
        be_in    = 4'b0001 << Address[1:0];
        wdata_in = {4{DataIn[7:0]}};
      end
      SZ_HALF: begin
        misalign = Address[0];
        be_in    = Address[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{DataIn[15:0]}};
      end
      default: begin
        misalign = |Address[1:0];
        be_in    = 4'b1111;
        wdata_in = DataIn;
      end
    endcase
  end

  always_comb begin
    case (lane_q)
      2'd0:    rd_byte = MReadData[7:0];
      2'd1:    rd_byte = MReadData[15:8];
      2'd2:    rd_byte = MReadData[23:16];
      default: rd_byte = MReadData[31:24];
    endcase
    rd_half = lane_q[1] ? MReadData[31:16] : MReadData[15:0];
    case (size_q)
      SZ_BYTE: load_fmt = {{24{sext_q & rd_byte[7]}}, rd_byte};
      SZ_HALF: load_fmt = {{16{sext_q & rd_half[15]}}, rd_half};
      default: load_fmt = MReadData;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    dout_d   = dout_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    be_d     = be_q;
    ren_d    = ren_q;
    wen_d    = wen_q;
    size_d   = size_q;
    lane_d   = lane_q;
    sext_d   = sext_q;
    load_d   = load_q;
`ifdef DMEM_TIMEOUT_EN
    cnt_d    = cnt_q;
    buserr_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req && !misalign) begin
          state_d  = S_WAIT;
          maddr_d  = Address[ADDR_W+1:2];
          mwdata_d = wdata_in;
          be_d     = be_in;
          ren_d    = ~MemWrite;
          wen_d    = MemWrite;
          size_d   = size_in;
          lane_d   = Address[1:0];
          sext_d   = SignExtend;
          load_d   = ~MemWrite;
`ifdef DMEM_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      S_WAIT: begin
        // An ack arriving on the expiry cycle still counts as a normal completion.
        if (DataMem_Ack) begin
          if (load_q) dout_d = load_fmt;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          state_d = S_DONE;
        end
`ifdef DMEM_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          if (load_q) dout_d = '0;
          ren_d    = 1'b0;
          wen_d    = 1'b0;
          buserr_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      dout_q   <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      be_q     <= '0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      size_q   <= SZ_WORD;
      lane_q   <= '0;
      sext_q   <= 1'b0;
      load_q   <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      cnt_q    <= '0;
      buserr_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      dout_q   <= dout_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      be_q     <= be_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
      size_q   <= size_d;
      lane_q   <= lane_d;
      sext_q   <= sext_d;
      load_q   <= load_d;
`ifdef DMEM_TIMEOUT_EN
      cnt_q    <= cnt_d;
      buserr_q <= buserr_d;
`endif
    end
  end

`ifdef DMEM_TIMEOUT_EN
  assign BusError = buserr_q;
`else
  assign BusError = 1'b0;
`endif

  assign Stall       = ((state_q == S_IDLE) && req && !misalign) || (state_q == S_WAIT);
  assign EXC_AdEL    = (state_q == S_IDLE) && MemRead && !MemWrite && misalign;
  assign EXC_AdES    = (state_q == S_IDLE) && MemWrite && misalign;
  assign DataOut     = dout_q;
  assign MAddr       = maddr_q;
  assign MWriteData  = mwdata_q;
  assign MByteEn     = be_q;
  assign ReadEnable  = ren_q;
  assign WriteEnable = wen_q;

endmodule
